// File: rtl/mips_pkg.sv
// Shared datapath constants for the MIPS register file and its decoder.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  // Number of registers addressed by an address of width aw.
  function automatic int nreg_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// N-bit address plus enable to 2**N one-hot vector.
module dec_onehot #(
  parameter int N = 5
) (
  input  logic [N-1:0]      adr,
  input  logic              en,
  output logic [2**N-1:0]   onehot
);

  // One comparator per output line; exactly one line is high when enabled.
  for (genvar g = 0; g < 2**N; g++) begin : g_line
    assign onehot[g] = en && (adr == N'(g));
  end

endmodule

// File: rtl/regfile_dec.sv
// Register file with one decoded write port and two read ports.
// Optional hardwired zero register, write-to-read bypass and registered reads.
module regfile_dec
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       WrEn,
  input  logic [ADDR_W-1:0]          WrAdr,
  input  logic [DATA_W-1:0]          WrData,
  input  logic [ADDR_W-1:0]          RdAdr1,
  input  logic [ADDR_W-1:0]          RdAdr2,
  output logic [DATA_W-1:0]          RdData1,
  output logic [DATA_W-1:0]          RdData2,
  output logic [nreg_of(ADDR_W)-1:0] WrOneHot
);

  localparam int NREG = nreg_of(ADDR_W);

  logic [NREG-1:0]   dec_raw;
  logic [NREG-1:0]   wr_onehot;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;

  dec_onehot #(.N(ADDR_W)) u_dec (
    .adr    (WrAdr),
    .en     (WrEn),
    .onehot (dec_raw)
  );

  // Mask the zero register out of the write decode so it can never be loaded.
  always_comb begin
    wr_onehot = dec_raw;
    if (ZERO_REG != 0) wr_onehot[ZERO_IDX] = 1'b0;
  end

  assign WrOneHot = wr_onehot;

  // Next array contents: each register loads WrData only when its decode line is set.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = wr_onehot[i] ? WrData : mem_q[i];
    end
  end

  // Register array; reset clears everything and discards a coincident write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read value for one port: zero register first, then bypass, then stored data.
  function automatic logic [DATA_W-1:0] read_path(
    input logic [ADDR_W-1:0] adr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic              rst,
    input logic [ADDR_W-1:0] wadr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if ((BYPASS != 0) && we && !rst && (wadr == adr)) v = wdata;
    if ((ZERO_REG != 0) && (adr == ADDR_W'(ZERO_IDX))) v = '0;
    return v;
  endfunction

  // Two identical read paths.
  always_comb begin
    rd1_val = read_path(RdAdr1, mem_q[RdAdr1], WrEn, Rst, WrAdr, WrData);
    rd2_val = read_path(RdAdr2, mem_q[RdAdr2], WrEn, Rst, WrAdr, WrData);
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    // Next output flop values are simply this cycle's read values.
    always_comb begin
      rd1_d = rd1_val;
      rd2_d = rd2_val;
    end

    // Output flops give a one-cycle read latency; cleared on reset.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end

    assign RdData1 = rd1_q;
    assign RdData2 = rd2_q;
  end else begin : g_rd_comb
    assign RdData1 = rd1_val;
    assign RdData2 = rd2_val;
  end

endmodule

// File: tb/tb_regfile_dec.sv
// Bench for regfile_dec: four parameterisations share one stimulus stream and are
// compared against an array-based reference model of the register file.
module tb_regfile_dec;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WrEn;
  logic [4:0]  WrAdr;
  logic [31:0] WrData;
  logic [4:0]  RdAdr1;
  logic [4:0]  RdAdr2;

  // a: defaults (zero reg, bypass, comb read)
  logic [31:0] a_rd1, a_rd2, a_oh;
  // b: ordinary r0, no bypass, registered read
  logic [31:0] b_rd1, b_rd2, b_oh;
  // c: ordinary r0, no bypass, comb read
  logic [31:0] c_rd1, c_rd2, c_oh;
  // d: zero reg, bypass, registered read
  logic [31:0] d_rd1, d_rd2, d_oh;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [31:0] mem_z [32];
  logic [31:0] mem_o [32];
  logic [31:0] exp_b1, exp_b2, exp_d1, exp_d2;

  // clock / reset block
  always #5 Clk = ~Clk;

  regfile_dec u_a (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAdr(WrAdr), .WrData(WrData),
    .RdAdr1(RdAdr1), .RdAdr2(RdAdr2), .RdData1(a_rd1), .RdData2(a_rd2), .WrOneHot(a_oh)
  );

  regfile_dec #(.ZERO_REG(0), .RD_REG(1), .BYPASS(0)) u_b (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAdr(WrAdr), .WrData(WrData),
    .RdAdr1(RdAdr1), .RdAdr2(RdAdr2), .RdData1(b_rd1), .RdData2(b_rd2), .WrOneHot(b_oh)
  );

  regfile_dec #(.ZERO_REG(0), .RD_REG(0), .BYPASS(0)) u_c (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAdr(WrAdr), .WrData(WrData),
    .RdAdr1(RdAdr1), .RdAdr2(RdAdr2), .RdData1(c_rd1), .RdData2(c_rd2), .WrOneHot(c_oh)
  );

  regfile_dec #(.ZERO_REG(1), .RD_REG(1), .BYPASS(1)) u_d (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAdr(WrAdr), .WrData(WrData),
    .RdAdr1(RdAdr1), .RdAdr2(RdAdr2), .RdData1(d_rd1), .RdData2(d_rd2), .WrOneHot(d_oh)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Value a read port should return, derived from the stated read rules.
  function automatic logic [31:0] ref_read(input logic [31:0] stored, input bit zero_reg,
                                           input bit bypass, input logic [4:0] adr,
                                           input bit rst, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (zero_reg && adr == 5'd0) return 32'd0;
    if (bypass && we && !rst && wa == adr) return wd;
    return stored;
  endfunction

  // One clock cycle: drive, check before the edge, advance the model at the edge.
  task automatic step(input bit rst, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] ra1, ra2, oh_o, oh_z;
    Rst = rst; WrEn = we; WrAdr = wa; WrData = wd; RdAdr1 = a1; RdAdr2 = a2;
    #4;
    oh_o = we ? (32'd1 << wa) : 32'd0;
    oh_z = (we && wa != 5'd0) ? (32'd1 << wa) : 32'd0;
    ra1 = ref_read(mem_z[a1], 1'b1, 1'b1, a1, rst, we, wa, wd);
    ra2 = ref_read(mem_z[a2], 1'b1, 1'b1, a2, rst, we, wa, wd);
    check("a_onehot", a_oh, oh_z);
    check("b_onehot", b_oh, oh_o);
    check("c_onehot", c_oh, oh_o);
    check("d_onehot", d_oh, oh_z);
    check("a_rd1", a_rd1, ra1);
    check("a_rd2", a_rd2, ra2);
    check("c_rd1", c_rd1, ref_read(mem_o[a1], 1'b0, 1'b0, a1, rst, we, wa, wd));
    check("c_rd2", c_rd2, ref_read(mem_o[a2], 1'b0, 1'b0, a2, rst, we, wa, wd));
    check("b_rd1", b_rd1, exp_b1);
    check("b_rd2", b_rd2, exp_b2);
    check("d_rd1", d_rd1, exp_d1);
    check("d_rd2", d_rd2, exp_d2);
    @(posedge Clk);
    exp_b1 = rst ? 32'd0 : mem_o[a1];
    exp_b2 = rst ? 32'd0 : mem_o[a2];
    exp_d1 = rst ? 32'd0 : ra1;
    exp_d2 = rst ? 32'd0 : ra2;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_z[i] = 32'd0;
        mem_o[i] = 32'd0;
      end
    end else if (we) begin
      mem_o[wa] = wd;
      if (wa != 5'd0) mem_z[wa] = wd;
    end
    #1;
  endtask

  initial begin
    logic [4:0] wa, a1, a2;
    Rst = 1'b1; WrEn = 1'b0; WrAdr = '0; WrData = '0; RdAdr1 = '0; RdAdr2 = '0;
    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      mem_z[i] = 32'd0;
      mem_o[i] = 32'd0;
    end
    exp_b1 = 32'd0; exp_b2 = 32'd0; exp_d1 = 32'd0; exp_d2 = 32'd0;

    // Every address reads zero after reset
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, $urandom, 5'(i), 5'(31 - i));

    // Basic writes to r5 and r31
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
    step(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd5);

    // Write to r0
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Same-cycle write/read of r7
    step(1'b0, 1'b1, 5'd7, 32'h1, 5'd3, 5'd4);
    step(1'b0, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

    // Back-to-back writes to one address
    step(1'b0, 1'b1, 5'd12, 32'h11, 5'd12, 5'd12);
    step(1'b0, 1'b1, 5'd12, 32'h22, 5'd12, 5'd12);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd12);

    // Reset beats a coincident write; next write works
    step(1'b0, 1'b1, 5'd9, 32'h33, 5'd9, 5'd5);
    step(1'b1, 1'b1, 5'd9, 32'h55, 5'd9, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd5);
    step(1'b0, 1'b1, 5'd9, 32'h77, 5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);

    // Random traffic, read addresses biased toward the write target
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), wa, $urandom, a1, a2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_dec.md
# regfile_dec

Parametrised register file built around a decoded (one-hot) write-enable vector; the successor to the fixed 5-to-32 address decoder. Provides one write port and two read ports for the MIPS datapath, with an optional hardwired zero register, write-to-read bypass and a selectable combinational or registered read mode. Sits between the ID stage (read addresses) and the WB stage (write port).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; register count `NREG = 2**ADDR_W`
- `ZERO_REG`, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary
- `RD_REG`, 0, 0 = combinational read; 1 = registered read, 1-cycle latency
- `BYPASS`, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns pre-write contents

Ports:
- `Clk` in 1: clock, all state updates on rising edge
- `Rst` in 1: synchronous, active-high reset
- `WrEn` in 1: write strobe
- `WrAdr` in ADDR_W: write register address
- `WrData` in DATA_W: write data
- `RdAdr1` in ADDR_W: read port 1 address
- `RdAdr2` in ADDR_W: read port 2 address
- `RdData1` out DATA_W: read port 1 data
- `RdData2` out DATA_W: read port 2 data
- `WrOneHot` out NREG: decoded write-enable vector, debug/trace (combinational)

## Operation
- `WrOneHot = WrEn ? (1 << WrAdr) : 0`; bit 0 forced to 0 when `ZERO_REG=1`.
- On rising `Clk` with `Rst=0`: every register `i` with `WrOneHot[i]=1` loads `WrData`; all others hold.
- `Rst=1` at a rising edge: all `NREG` registers cleared to 0; a write in the same cycle is discarded (reset wins).
- Read value per port p: `ZERO_REG && RdAdrp==0` -> 0; else if `BYPASS && WrEn && !Rst && WrAdr==RdAdrp` (and not the zero register) -> `WrData`; else stored contents.
- Both read ports are independent; both may address the same register, including the write target.
- `RD_REG=0`: `RdData1/2` drive the read value combinationally.
- `RD_REG=1`: `RdData1/2` are flops loaded with the read value each edge; reset value 0. With `BYPASS=0`, a write and read to the same address in one cycle return the old value next cycle.
- No state machine; state is the register array plus the optional output flops.

## Timing
- Write: data visible in the array one edge after `WrEn` is sampled.
- `RD_REG=0`: read latency 0 (same cycle as address); with `BYPASS=1` a same-cycle write is visible immediately.
- `RD_REG=1`: read latency 1; address sampled at edge N, data valid after edge N.
- Reset values: all registers 0; `RdData1/2` 0 in the cycle after reset (both modes, since the array is 0); `WrOneHot` follows `WrEn` and is not reset.
- Back-to-back writes to the same address every cycle: last write wins, no stall.
- Out-of-range addresses are impossible (full `2**ADDR_W` decode).

## Structure
- Shared package `mips_pkg`: `DATA_W`/`ADDR_W` defaults, `NREG` derivation, zero-register index constant.
- Sub-module `dec_onehot` (parameter `N`): `N`-bit address plus enable -> `2**N` one-hot output, generate-loop implementation; replaces the fixed gate-level decoder.
- `regfile_dec` instantiates one `dec_onehot`, the register array and two identical read-mux/bypass paths.

## Test plan
- Reset then read all 32 addresses on both ports -> every read 0; `WrOneHot` = 0 with `WrEn=0`.
- Write 0xDEADBEEF to r5, 0x12345678 to r31; next cycle read r5/r31 -> 0xDEADBEEF/0x12345678; `WrOneHot` = 0x00000020 then 0x80000000 during writes.
- `ZERO_REG=1`: write 0xFFFFFFFF to r0 -> `WrOneHot`=0, RdData1 for r0 = 0; `ZERO_REG=0`: same write -> reads 0xFFFFFFFF.
- `BYPASS=1, RD_REG=0`: r7=0x1, same cycle write r7=0xAA with `RdAdr1=RdAdr2=7` -> both ports 0xAA that cycle; `BYPASS=0` -> 0x1 that cycle, 0xAA next.
- `RD_REG=1`: set `RdAdr1=5` at edge N -> `RdData1` shows r5 only after edge N, previous value before.
- Assert `Rst` together with `WrEn` to r9=0x55 after r9=0x33 -> r9 reads 0 afterwards; write in next cycle works normally.
